// File: rtl/cc_completion_arbiter_if.sv
// Completion bus between the user-logic sources, the arbiter and the CC formatter.
// Per-requester fields are packed, requester i in slice i.
// slave  : arbiter view (consumes requests, produces the CC completion)
// master : environment view (drives requests and cc_ready)
interface cc_completion_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [16*NUM_REQ-1:0]   req_requester_id;
    logic [8*NUM_REQ-1:0]    req_tag;
    logic [3*NUM_REQ-1:0]    req_tc;
    logic [7*NUM_REQ-1:0]    req_lower_addr;
    logic [11*NUM_REQ-1:0]   req_dword_count;
    logic [3*NUM_REQ-1:0]    req_status;
    logic [128*NUM_REQ-1:0]  req_payload;

    logic                    cc_valid;
    logic                    cc_ready;
    logic                    cc_last;
    logic [15:0]             cc_requester_id;
    logic [7:0]              cc_tag;
    logic [2:0]              cc_tc;
    logic [6:0]              cc_lower_addr;
    logic [10:0]             cc_dword_count;
    logic [2:0]              cc_status;
    logic [127:0]            cc_payload;

    modport slave (
        input  req_valid, req_requester_id, req_tag, req_tc, req_lower_addr,
               req_dword_count, req_status, req_payload, cc_ready,
        output req_ready, cc_valid, cc_last, cc_requester_id, cc_tag, cc_tc,
               cc_lower_addr, cc_dword_count, cc_status, cc_payload
    );

    modport master (
        output req_valid, req_requester_id, req_tag, req_tc, req_lower_addr,
               req_dword_count, req_status, req_payload, cc_ready,
        input  req_ready, cc_valid, cc_last, cc_requester_id, cc_tag, cc_tc,
               cc_lower_addr, cc_dword_count, cc_status, cc_payload
    );
endinterface

// File: rtl/cc_completion_arbiter.sv
// Round-robin completion arbiter feeding a single CC formatter.
// One single-beat completion is held in an output register until cc_ready;
// a new completion may replace the outgoing one on the same edge.
// Optional statistics counters are enabled by defining CC_ARB_STATS_EN.
module cc_completion_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cc_completion_arbiter_if.slave bus,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy,
    output logic [31:0]           stat_cpl_count,
    output logic [31:0]           stat_stall_cycles
);
    localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [15:0]         rid_q, rid_d;
    logic [7:0]          tag_q, tag_d;
    logic [2:0]          tc_q, tc_d;
    logic [6:0]          laddr_q, laddr_d;
    logic [10:0]         dwc_q, dwc_d;
    logic [2:0]          status_q, status_d;
    logic [127:0]        payload_q, payload_d;

    logic [15:0]         rid_arr     [NUM_REQ];
    logic [7:0]          tag_arr     [NUM_REQ];
    logic [2:0]          tc_arr      [NUM_REQ];
    logic [6:0]          laddr_arr   [NUM_REQ];
    logic [10:0]         dwc_arr     [NUM_REQ];
    logic [2:0]          status_arr  [NUM_REQ];
    logic [127:0]        payload_arr [NUM_REQ];

    logic [IDX_W:0]      cand;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic                accept;
    logic                hs;
    logic                len_ok;

    // Unpack the per-requester slices so the capture mux can index by winner
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign rid_arr[gi]     = bus.req_requester_id[gi*16 +: 16];
        assign tag_arr[gi]     = bus.req_tag[gi*8 +: 8];
        assign tc_arr[gi]      = bus.req_tc[gi*3 +: 3];
        assign laddr_arr[gi]   = bus.req_lower_addr[gi*7 +: 7];
        assign dwc_arr[gi]     = bus.req_dword_count[gi*11 +: 11];
        assign status_arr[gi]  = bus.req_status[gi*3 +: 3];
        assign payload_arr[gi] = bus.req_payload[gi*128 +: 128];
    end

    // Round-robin search: first valid index at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_REQ_EXT) begin
                cand = cand - NUM_REQ_EXT;
            end
            if (!win_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Handshake: register free (or being drained this cycle) and a winner exists
    always_comb begin
        accept        = !rst && ((state_q == S_EMPTY) || bus.cc_ready);
        hs            = accept && win_found;
        bus.req_ready = '0;
        if (hs) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    // Next-state and capture; bad lengths become a completer abort with no data
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        rid_d     = rid_q;
        tag_d     = tag_q;
        tc_d      = tc_q;
        laddr_d   = laddr_q;
        dwc_d     = dwc_q;
        status_d  = status_q;
        payload_d = payload_q;
        len_ok    = (dwc_arr[win_idx] != 11'd0) && (dwc_arr[win_idx] <= 11'd4);
        if (hs) begin
            state_d  = S_HOLD;
            grant_d  = win_idx;
            rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            rid_d    = rid_arr[win_idx];
            tag_d    = tag_arr[win_idx];
            tc_d     = tc_arr[win_idx];
            laddr_d  = laddr_arr[win_idx];
            if (len_ok) begin
                dwc_d     = dwc_arr[win_idx];
                status_d  = status_arr[win_idx];
                payload_d = payload_arr[win_idx];
            end else begin
                dwc_d     = 11'd1;
                status_d  = 3'b100;
                payload_d = '0;
            end
        end else if ((state_q == S_HOLD) && bus.cc_ready) begin
            state_d = S_EMPTY;
        end
    end

    // State and holding register; reset discards any held completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            rid_q     <= '0;
            tag_q     <= '0;
            tc_q      <= '0;
            laddr_q   <= '0;
            dwc_q     <= '0;
            status_q  <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            rid_q     <= rid_d;
            tag_q     <= tag_d;
            tc_q      <= tc_d;
            laddr_q   <= laddr_d;
            dwc_q     <= dwc_d;
            status_q  <= status_d;
            payload_q <= payload_d;
        end
    end

    assign bus.cc_valid        = (state_q == S_HOLD);
    assign bus.cc_last         = (state_q == S_HOLD);
    assign busy                = (state_q == S_HOLD);
    assign grant_idx           = grant_q;
    assign bus.cc_requester_id = rid_q;
    assign bus.cc_tag          = tag_q;
    assign bus.cc_tc           = tc_q;
    assign bus.cc_lower_addr   = laddr_q;
    assign bus.cc_dword_count  = dwc_q;
    assign bus.cc_status       = status_q;
    assign bus.cc_payload      = payload_q;

`ifdef CC_ARB_STATS_EN
    logic [31:0] stat_cpl_q, stat_cpl_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Count delivered completions and formatter backpressure cycles (wrapping)
    always_comb begin
        stat_cpl_d   = stat_cpl_q;
        stat_stall_d = stat_stall_q;
        if (bus.cc_valid && bus.cc_ready) begin
            stat_cpl_d = stat_cpl_q + 32'd1;
        end
        if (bus.cc_valid && !bus.cc_ready) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpl_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_cpl_q   <= stat_cpl_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_cpl_count    = stat_cpl_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    assign stat_cpl_count    = 32'h0;
    assign stat_stall_cycles = 32'h0;
`endif
endmodule

// File: doc/cc_completion_arbiter.md
# cc_completion_arbiter

Round-robin scheduler that shares the single completer-completion (CC) formatter between `NUM_REQ` completion sources, e.g. BAR register file, config responder and DMA status. It sits between the user-logic completion sources and the CC formatter input. It accepts one single-beat completion (1–4 DWords) per request, holds it in an output register and presents it to the formatter until `cc_ready`. Back-to-back completions are supported at one per cycle.

## Interface
- `NUM_REQ`, 2 — number of completion sources (2..8).
- `IDX_W`, `$clog2(NUM_REQ)` (min 1) — grant index width.

Ports (per-requester fields are packed, requester *i* in slice *i*):
- `clk` in 1 — single clock domain.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in `NUM_REQ` — requester *i* has a completion pending.
- `req_ready` out `NUM_REQ` — combinational; a handshake on *i* occurs when `req_valid[i] & req_ready[i]`.
- `req_requester_id` in `16*NUM_REQ` — requester ID captured from the CQ.
- `req_tag` in `8*NUM_REQ` — tag.
- `req_tc` in `3*NUM_REQ` — traffic class.
- `req_lower_addr` in `7*NUM_REQ` — lower address.
- `req_dword_count` in `11*NUM_REQ` — payload DWords; legal values are 1..4.
- `req_status` in `3*NUM_REQ` — completion status.
- `req_payload` in `128*NUM_REQ` — read data; DW0 is in bits [31:0].
- `cc_valid` out 1 — to the formatter.
- `cc_requester_id` out 16, `cc_tag` out 8, `cc_tc` out 3, `cc_lower_addr` out 7, `cc_dword_count` out 11, `cc_status` out 3, `cc_payload` out 128 — registered completion fields.
- `cc_last` out 1 — equals `cc_valid`; every completion is single-beat.
- `cc_ready` in 1 — from the formatter; the integrator connects `s_axis_cc_tready[0]`.
- `grant_idx` out `IDX_W` — source of the completion currently held.
- `busy` out 1 — holding register occupied (equals `cc_valid`).
- `stat_cpl_count` out 32 — see Configuration.
- `stat_stall_cycles` out 32 — see Configuration.

## Operation
- **States:** EMPTY (`cc_valid=0`) and HOLD (`cc_valid=1`).
- **Accept condition:** `accept = EMPTY | (HOLD & cc_ready)`.
- **Arbitration:**
  - Round-robin over `req_valid`, starting at `rr_ptr` and wrapping at `NUM_REQ-1` → 0.
  - The winner is the first valid index at or after `rr_ptr`.
  - `req_ready` is one-hot at the winner when `accept` is true, otherwise all zero.
  - Non-winners are never readied in the same cycle.
- **Capture on handshake:**
  - All winner fields are loaded into the output registers.
  - `grant_idx` ← winner; `rr_ptr` ← (winner+1) mod `NUM_REQ`; state → HOLD.
- **Completion without new request:** if `cc_valid & cc_ready` and no handshake occurs, state → EMPTY and `cc_valid` ← 0.
- **Stability:** output fields are stable while in HOLD with `cc_ready=0`. Inputs are only sampled at a handshake.
- **Illegal length:** if `req_dword_count` is 0 or greater than 4, the capture substitutes:
  - `cc_status` = 3'b100 (completer abort),
  - `cc_dword_count` = 1,
  - `cc_payload` = 0.
  - Requester ID, tag, TC and lower address pass through unchanged.
- **Reset** (async, at any time, including mid-HOLD): the held completion is discarded.
  - `cc_valid`=0, all `cc_*` fields 0, `grant_idx`=0, `rr_ptr`=0, stats=0, `req_ready`=0 while `rst`=1.

## Timing
- Latency: handshake at edge N → `cc_valid`=1 from N+1.
- Throughput: one completion per cycle when `cc_ready` is held high and requests are pending.
- Combinational paths: `cc_ready` → `req_ready` and `req_valid` → `req_ready` are combinational. There are no paths from `req_*` to `cc_*` outputs.
- Simultaneous events:
  - **Formatter handshake and new request in the same cycle:** the new completion replaces the old one, `cc_valid` stays 1 and no bubble is inserted.
  - **All requesters valid continuously:** grants rotate 0,1,…,`NUM_REQ-1`,0.
  - **Single requester valid continuously:** it is granted every accept cycle; the pointer skips idle sources.
- `cc_valid` never deasserts without `cc_ready` (AXI-Stream rule).

## Configuration
- Macro `CC_ARB_STATS_EN`.
- **Defined:**
  - `stat_cpl_count` increments on every `cc_valid & cc_ready`.
  - `stat_stall_cycles` increments on every cycle with `cc_valid & !cc_ready`.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- **Undefined:** both outputs are tied to 32'h0 and no counter registers exist.

## Test plan
- **Single request:** `req_valid[0]`=1 with tag 0x15, dword_count 2, payload 0x…_DEADBEEF_CAFEF00D, `cc_ready`=1 → `req_ready[0]` in cycle 0; `cc_valid`=1 for exactly one cycle at cycle 1 with identical fields and `cc_last`=1.
- **Backpressure:** `cc_ready`=0 for 5 cycles after capture → `cc_valid` and all fields stable; `req_ready`=0 throughout; `stat_stall_cycles`=5 (macro on).
- **Fairness:** `NUM_REQ`=4, all valid, `cc_ready`=1 → `grant_idx` sequence 0,1,2,3,0 over consecutive cycles with no bubbles; `stat_cpl_count` increments each cycle.
- **Illegal length:** dword_count 7 with status 3'b000 → `cc_status`=3'b100, `cc_dword_count`=1, `cc_payload`=0, tag preserved.
- **Reset mid-HOLD:** assert `rst` asynchronously while `cc_valid`=1 → `cc_valid`=0 immediately, without waiting for a clock edge; after release, the first grant goes to index 0.
- **Back-to-back swap:** HOLD with requester 1 while requester 0 is valid; raise `cc_ready` → same edge completes requester 1 and captures requester 0; `cc_valid` stays 1; `grant_idx`=0.
